reg_file_gen2: RTL
==================

REG_FILE_GEN2 -- requirements
Module: reg_file_gen2

Interface
REQ-001 Parameter DW, default 8: register width in bits; DW >= 4.
REQ-002 Parameter NREG, default 16: registers per bank; power of two, >= 4; SW = log2(NREG).
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 din  input  DW  write data.
REQ-006 w_sel  input  SW  write register index.
REQ-007 write_en  input  1  write din to r[w_sel] at the next edge.
REQ-008 a_sel  input  SW  read port A index; bits [SW-1:1] also select the target pair.
REQ-009 b_sel  input  SW  read port B index; bits [SW-1:1] also select the source pair.
REQ-010 op  input  2  pair operation: 00 none, 01 PAIR_ADD, 10 PAIR_MOVE, 11 none (reserved).
REQ-011 constant  input  DW  signed PAIR_ADD operand.
REQ-012 bank_swap  input  1  single-cycle request to toggle the active bank.
REQ-013 outA  output  DW  r[a_sel] of the active bank, combinational.
REQ-014 outB  output  DW  r[b_sel] of the active bank, combinational.
REQ-015 outC  output  DW  high register of the B pair, r[{b_sel[SW-1:1],1}], combinational.
REQ-016 pair_a  output  2*DW  A pair {r[2k+1],r[2k]} with k = a_sel[SW-1:1], combinational.
REQ-017 zero_flag  output  1  registered; set when the last PAIR_ADD result was zero.
REQ-018 bank  output  1  registered active-bank index.

Function
REQ-019 Pair k SHALL be {r[2k+1] (high), r[2k] (low)}, 2*DW bits; a_sel[0] and b_sel[0] SHALL be ignored for pair selection.
REQ-020 PAIR_ADD SHALL write pair_a + sign-extend(constant, 2*DW) modulo 2^(2*DW) into the A pair at the next edge; wrap-around SHALL be silent.
REQ-021 PAIR_ADD SHALL load zero_flag with (result == 0) at the same edge; any other op SHALL hold zero_flag.
REQ-022 PAIR_MOVE SHALL copy the B pair into the A pair at the next edge; the same pair for A and B SHALL leave contents unchanged.
REQ-023 Single-port writes SHALL take effect in one cycle; outA/outB/outC/pair_a SHALL reflect them in the following cycle (no write-through bypass).
REQ-024 Collision: write_en with PAIR_ADD or PAIR_MOVE and w_sel inside the A pair -> din SHALL win for r[w_sel]; the other half of the pair SHALL take the pair-operation result.
REQ-025 Collision: write_en with w_sel outside the A pair -> both updates SHALL occur in the same edge.
REQ-026 zero_flag SHALL reflect the computed sum even when REQ-024 overrides one half.
REQ-027 op 11 SHALL modify no state.
REQ-028 Reads, writes and pair operations SHALL address the active bank only.
REQ-029 bank_swap SHALL toggle bank at the next edge; same-cycle writes and pair operations SHALL land in the bank active before the swap.

Reset
REQ-030 reset SHALL immediately and asynchronously clear every register in all banks, zero_flag and bank to 0, including in the middle of an operation.
REQ-031 While reset is high, write_en, op and bank_swap SHALL have no effect; operation SHALL resume at the first rising edge after deassertion.

Configuration
REQ-032 Macro SHADOW_BANK_EN defined: two banks of NREG registers; bank_swap operates per REQ-029.
REQ-033 Macro SHADOW_BANK_EN undefined: one bank only; bank_swap SHALL be ignored and bank SHALL be constant 0; all other behaviour SHALL be identical.

Verification (DW=8, NREG=16)
REQ-034 Reset sequence: write r5=0x3C, assert reset between edges -> all out* = 0 immediately, zero_flag=0, bank=0.
REQ-035 PAIR_ADD wrap: pair0 = 0xFFFF, constant=0x01 -> pair0=0x0000, zero_flag=1; then constant=0xFF -> pair0=0xFFFF, zero_flag=0.
REQ-036 PAIR_MOVE: pair 3 = 0x1234, a_sel=2, b_sel=7, op=10 -> r3:r2 = 0x1234; outC with b_sel=6 = 0x12.
REQ-037 Collision: pair1 = 0x00FF, PAIR_ADD constant=0x01 with write_en, w_sel=2, din=0xAA -> r3=0x01, r2=0xAA, zero_flag=0.
REQ-038 Shadow bank (SHADOW_BANK_EN defined): r4=0x11; bank_swap with write_en w_sel=4 din=0x22 -> bank=1, outA(a_sel=4)=0x00; swap again -> 0x22. With the macro undefined -> bank stays 0 and outA=0x22 throughout.

Source files
------------

// File: rtl/reg_file_gen2.sv
// Register file with paired 2*DW-bit add/move operations and an optional second
// register bank (SHADOW_BANK_EN); read ports are combinational, zero_flag/bank registered.
module reg_file_gen2 #(
    parameter int unsigned DW   = 8,
    parameter int unsigned NREG = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DW-1:0]            din,
    input  logic [$clog2(NREG)-1:0]  w_sel,
    input  logic                     write_en,
    input  logic [$clog2(NREG)-1:0]  a_sel,
    input  logic [$clog2(NREG)-1:0]  b_sel,
    input  logic [1:0]               op,
    input  logic [DW-1:0]            constant,
    input  logic                     bank_swap,
    output logic [DW-1:0]            outA,
    output logic [DW-1:0]            outB,
    output logic [DW-1:0]            outC,
    output logic [2*DW-1:0]          pair_a,
    output logic                     zero_flag,
    output logic                     bank
);

    localparam int unsigned SW = $clog2(NREG);
    localparam int unsigned PW = 2 * DW;
`ifdef SHADOW_BANK_EN
    localparam int unsigned NB = 2;
`else
    localparam int unsigned NB = 1;
`endif
    localparam int unsigned AW = $clog2(NB * NREG);

    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_MOVE = 2'b10;

    logic [DW-1:0] mem [NB*NREG];

    logic [AW-1:0] base;
    logic [AW-1:0] a_idx, b_idx, w_idx;
    logic [AW-1:0] a_lo, a_hi, b_lo, b_hi;
    logic [PW-1:0] pair_b;
    logic [PW-1:0] sum;
    logic [PW-1:0] result;
    logic          pair_op;

    // Physical addresses: the active bank occupies the upper address bit when present
    always_comb begin
        base  = AW'(bank) << SW;
        a_idx = base | AW'(a_sel);
        b_idx = base | AW'(b_sel);
        w_idx = base | AW'(w_sel);
        a_lo  = base | AW'({a_sel[SW-1:1], 1'b0});
        a_hi  = base | AW'({a_sel[SW-1:1], 1'b1});
        b_lo  = base | AW'({b_sel[SW-1:1], 1'b0});
        b_hi  = base | AW'({b_sel[SW-1:1], 1'b1});
    end

    always_comb begin
        outA    = mem[a_idx];
        outB    = mem[b_idx];
        outC    = mem[b_hi];
        pair_a  = {mem[a_hi], mem[a_lo]};
        pair_b  = {mem[b_hi], mem[b_lo]};
        sum     = pair_a + {{DW{constant[DW-1]}}, constant};
        result  = (op == OP_ADD) ? sum : pair_b;
        pair_op = (op == OP_ADD) || (op == OP_MOVE);
    end

    // Pair update first, then the single-port write so din wins on a collision
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NB * NREG); i++) begin
                mem[i] <= '0;
            end
            zero_flag <= 1'b0;
        end else begin
            if (pair_op) begin
                mem[a_hi] <= result[PW-1:DW];
                mem[a_lo] <= result[DW-1:0];
            end
            if (write_en) begin
                mem[w_idx] <= din;
            end
            if (op == OP_ADD) begin
                zero_flag <= (sum == '0);
            end
        end
    end

`ifdef SHADOW_BANK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank <= 1'b0;
        end else if (bank_swap) begin
            bank <= ~bank;
        end
    end
`else
    logic unused_bank_swap;
    assign unused_bank_swap = bank_swap;
    assign bank = 1'b0;
`endif

endmodule
